// File: rtl/ifstage.sv
// Instruction fetch stage: one outstanding imem request feeding a 2-entry {pc, instr} FIFO,
// with branch redirect that flushes the FIFO and drops any in-flight response.
module ifstage (
  input  logic        Clk,
  input  logic        Reset,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic        Instr_valid,
  input  logic        Dec_ready,
  input  logic        Br_taken,
  input  logic [31:0] PC_Immed
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  r_state, w_state_n;
  logic        r_req, w_req_n;
  logic [31:0] r_addr, w_addr_n;
  logic [31:0] r_fetch_pc, w_fetch_pc_n;
  logic [1:0]  r_cnt, w_cnt_n;
  logic [31:0] r_pc0, r_pc1, r_instr0, r_instr1;
  logic [31:0] w_pc0_n, w_pc1_n, w_instr0_n, w_instr1_n;

  logic        w_consume, w_redirect, w_ack, w_push;
  logic [31:0] w_target;

  assign Imem_req    = r_req;
  assign Imem_addr   = r_addr;
  assign PC          = r_pc0;
  assign Instr       = r_instr0;
  assign Instr_valid = (r_cnt != 2'd0);

  assign w_consume  = Instr_valid & Dec_ready;
  assign w_redirect = w_consume & Br_taken;
  assign w_target   = r_pc0 + 32'd4 + (PC_Immed << 2);
  assign w_ack      = Imem_ack & r_req;
  assign w_push     = w_ack & (r_state == S_REQ) & ~w_redirect;

  // FIFO next-state: a redirect flushes everything, including a same-cycle push
  always_comb begin
    w_cnt_n    = r_cnt;
    w_pc0_n    = r_pc0;
    w_pc1_n    = r_pc1;
    w_instr0_n = r_instr0;
    w_instr1_n = r_instr1;
    if (w_redirect) begin
      w_cnt_n = 2'd0;
    end else begin
      case ({w_push, w_consume})
        2'b01: begin
          w_pc0_n    = r_pc1;
          w_instr0_n = r_instr1;
          w_cnt_n    = r_cnt - 2'd1;
        end
        2'b10: begin
          if (r_cnt == 2'd0) begin
            w_pc0_n    = r_fetch_pc;
            w_instr0_n = Imem_rdata;
          end else begin
            w_pc1_n    = r_fetch_pc;
            w_instr1_n = Imem_rdata;
          end
          w_cnt_n = r_cnt + 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            w_pc0_n    = r_fetch_pc;
            w_instr0_n = Imem_rdata;
          end else begin
            w_pc0_n    = r_pc1;
            w_instr0_n = r_instr1;
            w_pc1_n    = r_fetch_pc;
            w_instr1_n = Imem_rdata;
          end
        end
        default: begin
          w_cnt_n = r_cnt;
        end
      endcase
    end
  end

  // Request sequencing: a new request may issue whenever none is in flight after this edge
  always_comb begin
    w_state_n = r_state;
    w_req_n   = r_req;
    w_addr_n  = r_addr;
    if (w_redirect) begin
      w_fetch_pc_n = w_target;
    end else if (w_push) begin
      w_fetch_pc_n = r_fetch_pc + 32'd4;
    end else begin
      w_fetch_pc_n = r_fetch_pc;
    end

    if ((r_state == S_IDLE) || w_ack) begin
      if (w_cnt_n != 2'd2) begin
        w_state_n = S_REQ;
        w_req_n   = 1'b1;
        w_addr_n  = w_fetch_pc_n;
      end else begin
        w_state_n = S_IDLE;
        w_req_n   = 1'b0;
      end
    end else if ((r_state == S_REQ) && w_redirect) begin
      w_state_n = S_DISCARD;
    end else begin
      w_state_n = r_state;
    end
  end

  // Control registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= 32'd0;
      r_fetch_pc <= 32'd0;
    end else begin
      r_state    <= w_state_n;
      r_req      <= w_req_n;
      r_addr     <= w_addr_n;
      r_fetch_pc <= w_fetch_pc_n;
    end
  end

  // FIFO storage; entries are cleared on reset so Instr/PC read zero
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt    <= 2'd0;
      r_pc0    <= 32'd0;
      r_pc1    <= 32'd0;
      r_instr0 <= 32'd0;
      r_instr1 <= 32'd0;
    end else begin
      r_cnt    <= w_cnt_n;
      r_pc0    <= w_pc0_n;
      r_pc1    <= w_pc1_n;
      r_instr0 <= w_instr0_n;
      r_instr1 <= w_instr1_n;
    end
  end

endmodule

// File: doc/ifstage.md
IFSTAGE -- requirements
Module: ifstage

Interface
REQ-001 Clk  in  1  single clock; all state updates on rising edge.
REQ-002 Reset  in  1  asynchronous, active-low; Reset=0 clears all state immediately regardless of Clk.
REQ-003 Imem_req  out  1  instruction-memory read request, registered.
REQ-004 Imem_addr  out  32  byte address of pending request, registered.
REQ-005 Imem_ack  in  1  memory returns Imem_rdata this cycle for the pending request; ignored when Imem_req=0.
REQ-006 Imem_rdata  in  32  instruction word, valid when Imem_ack=1.
REQ-007 Instr  out  32  instruction at FIFO head, presented to DECSTAGE Instr.
REQ-008 PC  out  32  byte address of Instr.
REQ-009 Instr_valid  out  1  Instr/PC hold a valid fetched instruction.
REQ-010 Dec_ready  in  1  decode accepts Instr this cycle; consume = Instr_valid & Dec_ready.
REQ-011 Br_taken  in  1  consumed instruction is a taken branch; sampled only on consume.
REQ-012 PC_Immed  in  32  sign-extended word offset from DECSTAGE Immed; sampled with Br_taken.

Function
REQ-013 Internal 2-entry FIFO of {pc, instr}; Instr/PC driven combinationally from head; Instr_valid = occupancy>0.
REQ-014 fetch_pc register holds next address to request; increments by 4 modulo 2^32 (0xFFFFFFFC+4=0x00000000).
REQ-015 At most one outstanding request; no branch delay slot.
REQ-016 FSM states: IDLE (Imem_req=0), REQ (Imem_req=1, data kept), REQ_DISCARD (Imem_req=1, data dropped).
REQ-017 Imem_addr and Imem_req held stable from request issue until the Imem_ack cycle inclusive.
REQ-018 IDLE -> REQ with Imem_addr=fetch_pc when post-edge occupancy <2 (after this edge's push/pop/flush).
REQ-019 REQ, Imem_ack=1, no redirect: push {fetch_pc, Imem_rdata}, fetch_pc+=4; next REQ (new addr, back-to-back) if post-edge occupancy <2, else IDLE.
REQ-020 Redirect = consume & Br_taken; target = PC + 4 + (PC_Immed<<2), 32-bit truncated.
REQ-021 Redirect: FIFO flushed (including any same-cycle push), fetch_pc=target.
REQ-022 Redirect in REQ without ack -> REQ_DISCARD; address unchanged.
REQ-023 Redirect in REQ with same-cycle ack -> acked data dropped; next state REQ at target.
REQ-024 REQ_DISCARD with ack -> data dropped, no push; next REQ at fetch_pc; without ack stay.
REQ-025 Simultaneous push and pop at occupancy 2 impossible by REQ-018/019; push+pop at occupancy 1 keeps occupancy 1 with order preserved.
REQ-026 Throughput: one instruction per cycle with zero-wait ack and Dec_ready=1; fetch-to-Instr_valid latency 1 cycle after ack edge.

Reset
REQ-027 While Reset=0: Imem_req=0, Imem_addr=0, Instr_valid=0, Instr=0, PC=0, FIFO empty, fetch_pc=0, state IDLE.
REQ-028 First cycle after Reset deasserts: Imem_req=1, Imem_addr=0x00000000.
REQ-029 Reset mid-request abandons it; a late Imem_ack is ignored.

Verification
REQ-030 Imem_ack=1, Dec_ready=1, rdata=addr -> Imem_addr 0,4,8,... each cycle; Instr_valid from cycle 2; PC/Instr advance by 4 per cycle.
REQ-031 Dec_ready=0 from reset -> FIFO holds PC 0,4; Imem_req drops, addr 8 not issued; Dec_ready=1 -> PC 0,4,8 in order, no gap.
REQ-032 Consume PC=0x08 with Br_taken=1, PC_Immed=3 -> next Imem_addr 0x18; PC 0x0C never presented.
REQ-033 Ack delayed 3 cycles, redirect at PC=0x20, PC_Immed=-3 during wait -> Imem_addr held until ack, data dropped, next request 0x18.
REQ-034 Redirect at PC=0, PC_Immed=-2 -> requests 0xFFFFFFFC then 0x00000000.
REQ-035 Reset pulsed low mid-REQ -> outputs clear immediately; after release first Imem_addr=0, stale ack ignored.
